// File: rtl/hamming74_tx.sv
// Hamming(7,4) encoder and framed serial transmitter: start bit, 7 code bits LSB first, stop bit(s).
// Optional HAMMING_TX_ERR_INJECT_EN adds err_mask[6:0], XORed into the codeword at capture.
module hamming74_tx #(
  parameter int BIT_CYCLES = 4,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] in_data,
  input  logic       in_valid,
`ifdef HAMMING_TX_ERR_INJECT_EN
  input  logic [6:0] err_mask,
`endif
  output logic       in_ready,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int CW = $clog2(BIT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]    bit_reg, bit_next;
  logic          stop_reg, stop_next;
  logic [6:0]    shreg_reg, shreg_next;
  logic          tx_reg, tx_next;
  logic          in_ready_reg, in_ready_next;
  logic          busy_reg, busy_next;
  logic          tx_done_reg, tx_done_next;

  logic [6:0] code;
  logic [6:0] cap_word;
  logic       cnt_last;

  assign code = {in_data[0] ^ in_data[1] ^ in_data[3],
                 in_data[0] ^ in_data[2] ^ in_data[3],
                 in_data[1] ^ in_data[2] ^ in_data[3],
                 in_data};

`ifdef HAMMING_TX_ERR_INJECT_EN
  assign cap_word = code ^ err_mask;
`else
  assign cap_word = code;
`endif

  assign cnt_last = (cnt_reg == CNT_LAST);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    stop_next  = stop_reg;
    shreg_next = shreg_reg;
    case (state_reg)
      IDLE: begin
        // Gate on the registered ready so nothing is captured in the cycle after reset release.
        if (in_valid && in_ready_reg) begin
          shreg_next = cap_word;
          cnt_next   = '0;
          bit_next   = 3'd0;
          stop_next  = 1'b0;
          state_next = START;
        end
      end
      START: begin
        if (cnt_last) begin
          cnt_next   = '0;
          state_next = DATA;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      DATA: begin
        if (cnt_last) begin
          cnt_next   = '0;
          shreg_next = {1'b0, shreg_reg[6:1]};
          if (bit_reg == 3'd6) begin
            stop_next  = 1'b0;
            state_next = STOP;
          end else begin
            bit_next = bit_reg + 3'd1;
          end
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      STOP: begin
        if (cnt_last) begin
          cnt_next = '0;
          if (stop_reg == STOP_LAST) begin
            state_next = IDLE;
          end else begin
            stop_next = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are derived from the next state so they are registered yet line up with the state.
  always_comb begin
    tx_next       = 1'b1;
    in_ready_next = 1'b0;
    busy_next     = 1'b1;
    tx_done_next  = 1'b0;
    case (state_next)
      IDLE: begin
        in_ready_next = 1'b1;
        busy_next     = 1'b0;
      end
      START:   tx_next = 1'b0;
      DATA:    tx_next = shreg_next[0];
      STOP:    tx_done_next = (cnt_next == CNT_LAST) && (stop_next == STOP_LAST);
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      bit_reg      <= 3'd0;
      stop_reg     <= 1'b0;
      shreg_reg    <= 7'd0;
      tx_reg       <= 1'b1;
      in_ready_reg <= 1'b0;
      busy_reg     <= 1'b0;
      tx_done_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      bit_reg      <= bit_next;
      stop_reg     <= stop_next;
      shreg_reg    <= shreg_next;
      tx_reg       <= tx_next;
      in_ready_reg <= in_ready_next;
      busy_reg     <= busy_next;
      tx_done_reg  <= tx_done_next;
    end
  end

  assign tx       = tx_reg;
  assign in_ready = in_ready_reg;
  assign busy     = busy_reg;
  assign tx_done  = tx_done_reg;

endmodule

// File: tb/tb_hamming74_tx.sv
// Bench for hamming74_tx: two instances (4 clk/bit, 1 stop and 1 clk/bit, 2 stops) checked
// against a frame model built from the parity equations and a receive-side syndrome decoder.
module tb_hamming74_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid_x [2];
  logic [3:0] in_data_x  [2];
  logic [6:0] err_mask_x [2];
  logic       tx_w [2], ready_w [2], busy_w [2], done_w [2];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  hamming74_tx #(.BIT_CYCLES(4), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data_x[0]), .in_valid(in_valid_x[0]),
`ifdef HAMMING_TX_ERR_INJECT_EN
    .err_mask(err_mask_x[0]),
`endif
    .in_ready(ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .tx_done(done_w[0])
  );

  hamming74_tx #(.BIT_CYCLES(1), .STOP_BITS(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data_x[1]), .in_valid(in_valid_x[1]),
`ifdef HAMMING_TX_ERR_INJECT_EN
    .err_mask(err_mask_x[1]),
`endif
    .in_ready(ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .tx_done(done_w[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int bc(input int sel);
    return (sel == 1) ? 1 : 4;
  endfunction

  function automatic int sb(input int sel);
    return (sel == 1) ? 2 : 1;
  endfunction

  // Reference encoder: each parity bit is the XOR of the data bits named in its equation.
  function automatic logic [6:0] encode(input logic [3:0] d);
    return {^(d & 4'b1011), ^(d & 4'b1101), ^(d & 4'b1110), d};
  endfunction

  // Far-end checker: each syndrome bit re-checks one parity group.
  function automatic logic [2:0] syndrome(input logic [6:0] c);
    return {^(c & 7'b1001011), ^(c & 7'b0101101), ^(c & 7'b0011110)};
  endfunction

  // Samples one complete frame starting with the cycle right after the capture edge.
  task automatic check_frame(input int sel, input logic [3:0] d);
    int         b = bc(sel);
    int         f = (8 + sb(sel)) * b;
    logic [6:0] exp_code = encode(d) ^ err_mask_x[sel];
    logic       line [10];
    logic       samp [40];
    int         wave_err = 0, ready_err = 0, busy_err = 0, done_err = 0;
    logic [6:0] got_code;
    line[0] = 1'b0;
    for (int k = 0; k < 7; k++) line[k+1] = exp_code[k];
    for (int k = 8; k < 10; k++) line[k] = 1'b1;
    for (int i = 0; i < f; i++) begin
      @(negedge clk);
      samp[i] = tx_w[sel];
      if (tx_w[sel] !== line[i / b]) wave_err++;
      if (ready_w[sel] !== 1'b0) ready_err++;
      if (busy_w[sel] !== 1'b1) busy_err++;
      if (done_w[sel] !== (i == f - 1)) done_err++;
    end
    for (int k = 0; k < 7; k++) got_code[k] = samp[(k + 1) * b + b / 2];
    $display("frame dut%0d data=%h code=%h expected=%h", sel, d, got_code, exp_code);
    check("tx_wave", wave_err, 0);
    check("ready_low_in_frame", ready_err, 0);
    check("busy_in_frame", busy_err, 0);
    check("tx_done_position", done_err, 0);
    check("codeword", got_code, exp_code);
    check("syndrome", syndrome(got_code), syndrome(err_mask_x[sel]));
    if (err_mask_x[sel] == 7'd0) check("recovered_data", got_code[3:0], d);
  endtask

  task automatic idle_check(input int sel);
    @(negedge clk);
    check("idle_tx", tx_w[sel], 1'b1);
    check("idle_ready", ready_w[sel], 1'b1);
    check("idle_busy", busy_w[sel], 1'b0);
  endtask

  task automatic wait_ready(input int sel, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ready_w[sel] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("ready_timeout", 0, 1);
  endtask

  task automatic capture(input int sel, input logic [3:0] d, input bit keep_valid,
                         input logic [3:0] d_after);
    in_valid_x[sel] = 1'b1;
    in_data_x[sel]  = d;
    @(posedge clk);
    #1;
    in_valid_x[sel] = keep_valid;
    in_data_x[sel]  = keep_valid ? d_after : 4'($urandom);
  endtask

  task automatic send(input int sel, input logic [3:0] d);
    bit ok;
    wait_ready(sel, ok);
    if (ok) begin
      capture(sel, d, 1'b0, 4'h0);
      check_frame(sel, d);
      idle_check(sel);
    end
  endtask

  initial begin
    bit         ok;
    logic [3:0] key;
    for (int s = 0; s < 2; s++) begin
      in_valid_x[s] = 1'b0;
      in_data_x[s]  = 4'h0;
      err_mask_x[s] = 7'd0;
    end

    // Reset state, then in_ready on the first edge after release.
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check("rst_tx", tx_w[s], 1'b1);
      check("rst_ready", ready_w[s], 1'b0);
      check("rst_busy", busy_w[s], 1'b0);
      check("rst_done", done_w[s], 1'b0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_rst", ready_w[0], 1'b1);

    send(0, 4'b1011);

    // in_valid held high: 0 then F, one idle cycle between frames.
    wait_ready(0, ok);
    if (ok) begin
      capture(0, 4'h0, 1'b1, 4'hF);
      check_frame(0, 4'h0);
      idle_check(0);
      @(posedge clk);
      #1;
      in_valid_x[0] = 1'b0;
      check_frame(0, 4'hF);
      idle_check(0);
    end

    // All 16 nibbles on both configurations, in a randomised order.
    key = 4'($urandom);
    for (int i = 0; i < 16; i++) send(0, 4'(i) ^ key);
    key = 4'($urandom);
    for (int i = 0; i < 16; i++) send(1, 4'(i) ^ key);
    send(1, 4'h5);

    // Reset in the middle of data bit 3.
    wait_ready(0, ok);
    if (ok) begin
      capture(0, 4'($urandom), 1'b0, 4'h0);
      repeat (4 + 3 * 4 + 1) @(negedge clk);
      check("pre_abort_busy", busy_w[0], 1'b1);
      #1 rst_n = 1'b0;
      #1;
      check("abort_tx", tx_w[0], 1'b1);
      check("abort_busy", busy_w[0], 1'b0);
      check("abort_ready", ready_w[0], 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("ready_after_abort", ready_w[0], 1'b1);
      send(0, 4'h5);
    end

`ifdef HAMMING_TX_ERR_INJECT_EN
    err_mask_x[0] = 7'b0000100;
    send(0, 4'hA);
    err_mask_x[0] = 7'b0;
`endif

    for (int i = 0; i < 4; i++) send(i % 2, 4'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
